// File: rtl/pkt_tx_gen.sv
// Packet transmit generator: buffers one payload from a streaming source, then frames it
// with a 10-byte header (da, sa, 32-bit length, 32-bit additive crc) and plays it to the router.
module pkt_tx_gen #(
  parameter int PAYLOAD_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  input  logic [7:0]  hdr_da,
  input  logic [7:0]  hdr_sa,
  input  logic        dut_busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_done,
  output logic        err_short,
  output logic [15:0] pkt_count
);

  localparam int CW = $clog2(PAYLOAD_DEPTH + 1);
  localparam int AW = $clog2(PAYLOAD_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(PAYLOAD_DEPTH);

  localparam logic [2:0] S_LOAD    = 3'd0;
  localparam logic [2:0] S_ARB     = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  logic [2:0]    state;
  logic [7:0]    mem [PAYLOAD_DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] rd_idx;
  logic [31:0]   crc;
  logic [7:0]    da_q;
  logic [7:0]    sa_q;
  logic [3:0]    hdr_idx;
  logic          gap_cnt;
  logic          armed;

  logic          accept;
  logic          closing;
  logic [CW-1:0] count_inc;
  logic [31:0]   length;
  logic [7:0]    tx_byte;

  // armed holds pl_ready low until the first clock edge after reset release
  assign pl_ready  = armed && (state == S_LOAD) && (count < DEPTH_C);
  assign accept    = pl_valid && pl_ready;
  assign count_inc = count + CW'(1);
  assign closing   = pl_last || (count_inc == DEPTH_C);
  assign length    = 32'(count) + 32'd10;
  assign tx_valid  = (state == S_HDR) || (state == S_PAYLOAD);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[count[AW-1:0]] <= pl_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_LOAD;
      count     <= '0;
      rd_idx    <= '0;
      crc       <= '0;
      da_q      <= '0;
      sa_q      <= '0;
      hdr_idx   <= '0;
      gap_cnt   <= 1'b0;
      armed     <= 1'b0;
      tx_done   <= 1'b0;
      err_short <= 1'b0;
      pkt_count <= '0;
    end else begin
      armed     <= 1'b1;
      tx_done   <= 1'b0;
      err_short <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
            // a packet closed after its very first byte is too short to frame
            if (closing && (count == '0)) begin
              count     <= '0;
              crc       <= '0;
              err_short <= 1'b1;
            end else begin
              count <= count_inc;
              crc   <= crc + 32'(pl_data);
              if (closing) begin
                da_q  <= hdr_da;
                sa_q  <= hdr_sa;
                state <= S_ARB;
              end
            end
          end
        end
        S_ARB: begin
          if (!dut_busy) begin
            hdr_idx <= '0;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          hdr_idx <= hdr_idx + 4'd1;
          if (hdr_idx == 4'd9) begin
            rd_idx <= '0;
            state  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          rd_idx <= rd_idx + CW'(1);
          if (rd_idx == (count - CW'(1))) begin
            tx_done   <= 1'b1;
            pkt_count <= pkt_count + 16'd1;
            gap_cnt   <= 1'b0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          gap_cnt <= 1'b1;
          if (gap_cnt) begin
            count <= '0;
            crc   <= '0;
            state <= S_LOAD;
          end
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

  // header bytes go out most-significant first for both length and crc
  always_comb begin
    tx_byte = mem[rd_idx[AW-1:0]];
    if (state == S_HDR) begin
      case (hdr_idx)
        4'd0:    tx_byte = da_q;
        4'd1:    tx_byte = sa_q;
        4'd2:    tx_byte = length[31:24];
        4'd3:    tx_byte = length[23:16];
        4'd4:    tx_byte = length[15:8];
        4'd5:    tx_byte = length[7:0];
        4'd6:    tx_byte = crc[31:24];
        4'd7:    tx_byte = crc[23:16];
        4'd8:    tx_byte = crc[15:8];
        4'd9:    tx_byte = crc[7:0];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign tx_data = tx_valid ? tx_byte : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_pkt_tx_gen.sv
// Scoreboard bench for pkt_tx_gen: directed packets push hand-computed wire bytes,
// a negedge monitor pops and compares every byte the DUT drives.
module tb_pkt_tx_gen;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_last;
  logic        pl_ready;
  logic [7:0]  hdr_da;
  logic [7:0]  hdr_sa;
  logic        dut_busy;
  wire  [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_done;
  logic        err_short;
  logic [15:0] pkt_count;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];
  int exp_len_q[$];
  int bytes_seen = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic prev_valid = 1'b0;

  pkt_tx_gen #(.PAYLOAD_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_last   (pl_last),
    .pl_ready  (pl_ready),
    .hdr_da    (hdr_da),
    .hdr_sa    (hdr_sa),
    .dut_busy  (dut_busy),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_done   (tx_done),
    .err_short (err_short),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // a two-state simulator resolves a released bus to zero rather than Z
  task automatic checkIdle(input string name);
    compared++;
    if ((tx_data !== 8'hzz) && (tx_data !== 8'h00)) begin
      mismatched++;
      $display("[TB] FAIL %s: tx_data got %h, required zz at %0t", name, tx_data, $time);
    end
  endtask

  task automatic push_hdr(input logic [7:0] da, input logic [7:0] sa,
                          input logic [31:0] len, input logic [31:0] crc);
    exp_q.push_back(da);
    exp_q.push_back(sa);
    for (int i = 3; i >= 0; i--) exp_q.push_back(len[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(crc[i*8 +: 8]);
  endtask

  task automatic push_payload(input logic [7:0] payload[$]);
    foreach (payload[i]) exp_q.push_back(payload[i]);
  endtask

  task automatic applyStimulus(input logic [7:0] da, input logic [7:0] sa,
                               input logic [7:0] payload[$], input bit use_last);
    int waited;
    hdr_da = da;
    hdr_sa = sa;
    foreach (payload[i]) begin
      pl_data  = payload[i];
      pl_valid = 1'b1;
      pl_last  = use_last && (i == payload.size() - 1);
      waited   = 0;
      while (!pl_ready && waited < 300) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!pl_ready) begin
        checkOutput("pl_ready_timeout", 32'(pl_ready), 32'd1);
        pl_valid = 1'b0;
        pl_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    pl_valid = 1'b0;
    pl_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_count", 32'(done_seen), 32'(target));
  endtask

  // monitor: every driven byte is popped from the scoreboard, every idle cycle must release the bus
  always @(negedge clk) begin
    if (tx_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_byte: got 0x%0h, required no byte at %0t", tx_data, $time);
      end else begin
        checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      bytes_seen++;
    end else begin
      checkIdle("idle_bus");
    end
    if (tx_done) begin
      checkOutput("done_after_last", {30'd0, prev_valid, tx_valid}, 32'd2);
      if (exp_len_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got %0d bytes, required no packet at %0t", bytes_seen, $time);
      end else begin
        checkOutput("pkt_len", 32'(bytes_seen), 32'(exp_len_q.pop_front()));
      end
      bytes_seen = 0;
      done_seen++;
    end
    if (err_short) err_seen++;
    prev_valid = tx_valid;
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] pl2[$];
    int gap;
    int busy_viol;
    int n;

    pl_data  = 8'h00;
    pl_valid = 1'b0;
    pl_last  = 1'b0;
    hdr_da   = 8'h00;
    hdr_sa   = 8'h00;
    dut_busy = 1'b0;

    #1 reset = 1'b0;
    #1;
    checkOutput("rst_pl_ready", 32'(pl_ready), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_done", 32'(tx_done), 32'd0);
    checkOutput("rst_err_short", 32'(err_short), 32'd0);
    checkOutput("rst_pkt_count", 32'(pkt_count), 32'd0);
    checkIdle("rst_tx_data");

    #20 reset = 1'b1;
    #1;
    checkOutput("ready_before_edge", 32'(pl_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_after_edge", 32'(pl_ready), 32'd1);

    // single byte closed by pl_last is discarded
    pl = '{8'h9C};
    applyStimulus(8'h01, 8'h02, pl, 1'b1);
    checkOutput("err_short_pulse", 32'(err_short), 32'd1);
    @(posedge clk); #1;
    checkOutput("err_short_clear", 32'(err_short), 32'd0);
    checkOutput("load_after_err", 32'(pl_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("err_pulses", 32'(err_seen), 32'd1);
    checkOutput("pkt_count_err", 32'(pkt_count), 32'd0);

    // basic two-byte packet: length 12 = 0x0C, crc 5+7 = 0x0C
    pl = '{8'h05, 8'h07};
    push_hdr(8'h11, 8'h22, 32'h0000_000C, 32'h0000_000C);
    push_payload(pl);
    exp_len_q.push_back(12);
    applyStimulus(8'h11, 8'h22, pl, 1'b1);
    checkOutput("latency_edge1", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("latency_edge2", 32'(tx_valid), 32'd1);
    wait_done(1);
    checkOutput("pkt_count_1", 32'(pkt_count), 32'd1);

    // full buffer of 0xFF closes without pl_last: length 266 = 0x10A, crc 256*255 = 0xFF00
    pl.delete();
    for (int i = 0; i < DEPTH; i++) pl.push_back(8'hFF);
    push_hdr(8'h3C, 8'hC3, 32'h0000_010A, 32'h0000_FF00);
    push_payload(pl);
    exp_len_q.push_back(266);
    applyStimulus(8'h3C, 8'hC3, pl, 1'b0);
    checkOutput("autoclose_ready", 32'(pl_ready), 32'd0);
    wait_done(2);
    checkOutput("pkt_count_2", 32'(pkt_count), 32'd2);

    // router busy holds the packet in arbitration; crc 0xAA+0x55 = 0xFF
    dut_busy = 1'b1;
    pl = '{8'hAA, 8'h55};
    push_hdr(8'h5A, 8'hA5, 32'h0000_000C, 32'h0000_00FF);
    push_payload(pl);
    exp_len_q.push_back(12);
    applyStimulus(8'h5A, 8'hA5, pl, 1'b1);
    busy_viol = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx_valid) busy_viol++;
    end
    checkOutput("busy_hold", 32'(busy_viol), 32'd0);
    dut_busy = 1'b0;
    @(posedge clk); #1;
    checkOutput("start_after_busy", 32'(tx_valid), 32'd1);
    dut_busy = 1'b1;
    wait_done(3);
    dut_busy = 1'b0;
    checkOutput("pkt_count_3", 32'(pkt_count), 32'd3);

    // back-to-back packets, next source byte offered while the first is on the wire
    pl  = '{8'h01, 8'h02, 8'h03, 8'h04};
    pl2 = '{8'h10, 8'h20, 8'h30, 8'h40};
    push_hdr(8'h44, 8'h55, 32'h0000_000E, 32'h0000_000A);
    push_payload(pl);
    exp_len_q.push_back(14);
    push_hdr(8'h66, 8'h77, 32'h0000_000E, 32'h0000_00A0);
    push_payload(pl2);
    exp_len_q.push_back(14);
    applyStimulus(8'h44, 8'h55, pl, 1'b1);
    pl_data  = pl2[0];
    pl_valid = 1'b1;
    n = 0;
    while (!tx_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_seen_a", 32'(tx_done), 32'd1);
    gap = 0;
    while (!pl_ready && gap < 10) begin
      gap++;
      @(posedge clk); #1;
    end
    checkOutput("gap_cycles", 32'(gap), 32'd2);
    applyStimulus(8'h66, 8'h77, pl2, 1'b1);
    wait_done(5);
    checkOutput("pkt_count_5", 32'(pkt_count), 32'd5);

    // reset in the middle of the payload drops the packet
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_hdr(8'h77, 8'h88, 32'h0000_0012, 32'h0000_0024);
    push_payload(pl);
    exp_len_q.push_back(18);
    applyStimulus(8'h77, 8'h88, pl, 1'b1);
    n = 0;
    while (bytes_seen < 12 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reached_payload", 32'(bytes_seen >= 12), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
    checkIdle("midrst_tx_data");
    checkOutput("midrst_pkt_count", 32'(pkt_count), 32'd0);
    checkOutput("midrst_pl_ready", 32'(pl_ready), 32'd0);
    exp_q.delete();
    exp_len_q.delete();
    bytes_seen = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // 0x33+0x44+0x55 = 0xCC, length 13 = 0x0D
    pl = '{8'h33, 8'h44, 8'h55};
    push_hdr(8'h99, 8'h66, 32'h0000_000D, 32'h0000_00CC);
    push_payload(pl);
    exp_len_q.push_back(13);
    applyStimulus(8'h99, 8'h66, pl, 1'b1);
    wait_done(6);
    checkOutput("pkt_count_after_rst", 32'(pkt_count), 32'd1);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
